// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences IF fetches and MEM loads/stores onto one fixed-latency single-port memory, ack LATENCY+2 cycles after grant.
// MEM wins collisions; defining MEM_ARB_FAIRNESS_EN grants IF after STARVE_MAX consecutive MEM grants made while IF waited.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stallreq_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_sel_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  if (LATENCY < 1 || STARVE_MAX < 1) begin : g_cfg_check
    $error("mem_arbiter: LATENCY and STARVE_MAX must both be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_id_mem;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_sel;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_if_data;
  logic [31:0]   r_mem_data;
  logic          w_grant;
  logic          w_grant_mem;
  logic          w_if_turn;
  logic          w_capture;
  logic [CW-1:0] w_cnt_inc;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned SW = ($clog2(STARVE_MAX + 1) < 3) ? 3 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  assign w_if_turn = if_req_i && (r_starve == SW'(STARVE_MAX));

  // Counts MEM grants that overtook a waiting IF; any IF grant or idle IF clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE) begin
      if (if_req_i && w_grant_mem) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end
`else
  assign w_if_turn = 1'b0;
`endif

  assign w_grant     = if_req_i | mem_req_i;
  assign w_grant_mem = mem_req_i & ~w_if_turn;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_capture   = (r_state == S_WAIT) && (w_cnt_inc == LAT_C);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_capture) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_id_mem   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_if_data  <= '0;
      r_mem_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_grant) begin
        r_id_mem <= w_grant_mem;
        if (w_grant_mem) begin
          r_we    <= mem_we_i;
          r_addr  <= mem_addr_i;
          r_wdata <= mem_wdata_i;
          r_sel   <= mem_sel_i;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= if_addr_i;
          r_sel   <= 4'b1111;
        end
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      // Writes leave both return registers untouched.
      if (w_capture && !r_we) begin
        if (r_id_mem) begin
          r_mem_data <= ram_rdata_i;
        end else begin
          r_if_data  <= ram_rdata_i;
        end
      end
    end
  end

  assign ram_ce_o    = (r_state == S_ISSUE);
  assign ram_we_o    = (r_state == S_ISSUE) & r_we;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = r_wdata;
  assign ram_sel_o   = r_sel;
  assign if_ack_o    = (r_state == S_DONE) & ~r_id_mem;
  assign mem_ack_o   = (r_state == S_DONE) & r_id_mem;
  assign if_data_o   = r_if_data;
  assign mem_data_o  = r_mem_data;
  assign stallreq_o  = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: IF and MEM requesters against a transaction-level memory model and arbitration rules.
module tb_mem_arbiter;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;
  localparam int          TMO  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stallreq_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_rdata_i = '0;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i), .mem_data_o(mem_data_o), .mem_ack_o(mem_ack_o),
    .stallreq_o(stallreq_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_sel_o(ram_sel_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory device seen by the DUT, and the reference contents used for expectations.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h3401_0020;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  // Scoreboard: expected return data (pushed at issue) and expected ack cycle (pushed at strobe).
  logic [31:0] if_dq[$];
  logic [31:0] mem_dq[$];
  int          if_tq[$];
  int          mem_tq[$];
  logic [31:0] last_mem_rd = '0;

  // Read data is only valid in exactly one cycle; junk elsewhere exposes early/late capture.
  bit          rd_pend = 1'b0;
  int          rd_cyc = 0;
  logic [31:0] rd_val = '0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_pend && cyc == rd_cyc) begin
      ram_rdata_i = rd_val;
      rd_pend = 1'b0;
    end else begin
      ram_rdata_i = $urandom;
    end
  end

  bit          mon_en = 1'b0;
  bit          prev_ce = 1'b0;
  bit          win_mem;
  bit          exp_if_ack, exp_mem_ack;
  logic        d_if = 1'b0, d_mem = 1'b0, d_mem_we = 1'b0;
  logic [31:0] d_if_addr = '0, d_mem_addr = '0, d_mem_wdata = '0;
  logic [3:0]  d_mem_sel = '0;
  int          if_ack_n = 0, mem_ack_n = 0, mem_at_if_ack = 0;
  int          if_ce_cyc = 0, ce_cyc = 0, if_ack_cyc = 0, mem_ack_cyc = 0;
  logic [31:0] st_addr = '0, st_wdata = '0;
  logic [3:0]  st_sel = '0;
  logic        st_we = 1'b0;
  bit          stall_hist [int];
`ifdef MEM_ARB_FAIRNESS_EN
  int          starve = 0;
`endif

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      exp_if_ack  = (if_tq.size() > 0) && (if_tq[0] == cyc);
      exp_mem_ack = (mem_tq.size() > 0) && (mem_tq[0] == cyc);
      stall_hist[cyc] = stallreq_o;
      chk("stallreq", stallreq_o, (if_req_i && !exp_if_ack) || (mem_req_i && !exp_mem_ack));

      if (if_ack_o) begin
        if_ack_n++;
        if_ack_cyc = cyc;
        mem_at_if_ack = mem_ack_n;
        if (if_tq.size() == 0) fail("if_ack_unexpected", 1, 0);
        else chk("if_ack_cycle", cyc, if_tq.pop_front());
        if (if_dq.size() == 0) fail("if_data_unexpected", if_data_o, 0);
        else chk("if_data", if_data_o, if_dq.pop_front());
      end else if (if_tq.size() > 0 && if_tq[0] <= cyc) begin
        fail("if_ack_missing", 0, 1);
        void'(if_tq.pop_front());
        if (if_dq.size() > 0) void'(if_dq.pop_front());
      end

      if (mem_ack_o) begin
        mem_ack_n++;
        mem_ack_cyc = cyc;
        if (mem_tq.size() == 0) fail("mem_ack_unexpected", 1, 0);
        else chk("mem_ack_cycle", cyc, mem_tq.pop_front());
        if (mem_dq.size() == 0) fail("mem_data_unexpected", mem_data_o, 0);
        else chk("mem_data", mem_data_o, mem_dq.pop_front());
      end else if (mem_tq.size() > 0 && mem_tq[0] <= cyc) begin
        fail("mem_ack_missing", 0, 1);
        void'(mem_tq.pop_front());
        if (mem_dq.size() > 0) void'(mem_dq.pop_front());
      end

      if (ram_ce_o) begin
        chk("ce_single_cycle", prev_ce, 0);
        ce_cyc = cyc;
        st_addr = ram_addr_o; st_wdata = ram_wdata_o; st_sel = ram_sel_o; st_we = ram_we_o;
        if (!d_if && !d_mem) begin
          fail("strobe_without_request", 1, 0);
        end else begin
          win_mem = d_mem;
`ifdef MEM_ARB_FAIRNESS_EN
          if (d_if && d_mem && starve == SMAX) win_mem = 1'b0;
          if (win_mem && d_if) starve++;
          else starve = 0;
`endif
          if (win_mem) begin
            chk("mem_strobe_addr", ram_addr_o, d_mem_addr);
            chk("mem_strobe_we", ram_we_o, d_mem_we);
            chk("mem_strobe_sel", ram_sel_o, d_mem_sel);
            if (d_mem_we) chk("mem_strobe_wdata", ram_wdata_o, d_mem_wdata);
            mem_tq.push_back(cyc + LAT + 1);
          end else begin
            if_ce_cyc = cyc;
            chk("if_strobe_addr", ram_addr_o, d_if_addr);
            chk("if_strobe_we", ram_we_o, 0);
            chk("if_strobe_sel", ram_sel_o, 4'hF);
            if_tq.push_back(cyc + LAT + 1);
          end
        end
        if (ram_we_o) begin
          dev_mem[ram_addr_o] = merge(dev_rd(ram_addr_o), ram_wdata_o, ram_sel_o);
        end else begin
          rd_pend = 1'b1;
          rd_cyc  = cyc + LAT;
          rd_val  = dev_rd(ram_addr_o);
        end
      end else if (ram_we_o) begin
        fail("we_without_ce", 1, 0);
      end
    end
    prev_ce = ram_ce_o;
    d_if = if_req_i; d_if_addr = if_addr_i;
    d_mem = mem_req_i; d_mem_we = mem_we_i; d_mem_addr = mem_addr_i;
    d_mem_wdata = mem_wdata_i; d_mem_sel = mem_sel_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_mem);
    bit got;
    got = 1'b0;
    for (int n = 0; n < TMO && !got; n++) begin
      @(negedge clk);
      got = is_mem ? mem_ack_o : if_ack_o;
    end
    if (!got) fail(is_mem ? "mem_ack_timeout" : "if_ack_timeout", 0, 1);
    step();
  endtask

  task automatic if_txn(input logic [31:0] a);
    if_addr_i = a;
    if_req_i  = 1'b1;
    if_dq.push_back(ref_rd(a));
    wait_ack(1'b0);
    if_req_i = 1'b0;
  endtask

  task automatic mem_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sel);
    mem_we_i = we; mem_addr_i = a; mem_wdata_i = wd; mem_sel_i = sel;
    mem_req_i = 1'b1;
    if (we) begin
      ref_mem[a] = merge(ref_rd(a), wd, sel);
    end else begin
      last_mem_rd = ref_rd(a);
    end
    mem_dq.push_back(last_mem_rd);
    wait_ack(1'b1);
    mem_req_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    if_dq.delete(); mem_dq.delete(); if_tq.delete(); mem_tq.delete();
    last_mem_rd = '0;
`ifdef MEM_ARB_FAIRNESS_EN
    starve = 0;
`endif
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, required finish before 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  int t0, t1, m0, i0;

  initial begin
    // Reset: two cycles, all outputs low.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_if_ack", if_ack_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_mem_ack", mem_ack_o, 0);
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_ram_ce", ram_ce_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_wdata", ram_wdata_o, 0);
    chk("rst_ram_sel", ram_sel_o, 0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single IF read of the preloaded word.
    t0 = cyc;
    if_txn(32'h10);
    chk("if_single_strobe_cycle", if_ce_cyc, t0 + 1);
    chk("if_single_ack_cycle", if_ack_cyc, t0 + 4);
    chk("if_single_data", if_data_o, 32'h3401_0020);
    for (int k = 0; k < 4; k++) chk("if_single_stall_high", stall_hist[t0 + k], 1);
    chk("if_single_stall_ack_low", stall_hist[t0 + 4], 0);

    // MEM partial write, then read it back.
    t0 = cyc;
    mem_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    chk("wr_strobe_cycle", ce_cyc, t0 + 1);
    chk("wr_strobe_addr", st_addr, 32'h100);
    chk("wr_strobe_wdata", st_wdata, 32'hDEAD_BEEF);
    chk("wr_strobe_sel", st_sel, 4'b0011);
    chk("wr_strobe_we", st_we, 1);
    chk("wr_ack_cycle", mem_ack_cyc, t0 + 4);
    chk("wr_mem_data_kept", mem_data_o, 0);
    mem_txn(1'b0, 32'h100, 32'h0, 4'hF);

    // Collision: MEM first, IF in the following IDLE.
    t0 = cyc;
    fork
      if_txn(32'h4);
      mem_txn(1'b0, 32'h104, 32'h0, 4'hF);
    join
    chk("coll_mem_ack_cycle", mem_ack_cyc, t0 + 4);
    chk("coll_if_strobe_cycle", if_ce_cyc, t0 + 6);
    chk("coll_if_ack_cycle", if_ack_cyc, t0 + 9);

    // Reset during WAIT of an IF read: aborted, then a fresh read starting next cycle.
    i0 = if_ack_n;
    if_addr_i = 32'h7;
    if_req_i = 1'b1;
    step();
    step();
    do_reset(1);
    chk("abort_ce_low", ram_ce_o, 0);
    chk("abort_if_data_cleared", if_data_o, 0);
    t1 = cyc;
    if_txn(32'h7);
    chk("after_abort_strobe_cycle", if_ce_cyc, t1 + 1);
    chk("after_abort_ack_cycle", if_ack_cyc, t1 + 4);
    chk("abort_if_ack_count", if_ack_n - i0, 1);

    // Starvation: MEM requests back-to-back while IF waits.
    m0 = mem_ack_n;
    fork
      if_txn(32'h2);
      for (int k = 0; k < 6; k++) mem_txn(1'b0, 32'h101 + k, 32'h0, 4'hF);
    join
`ifdef MEM_ARB_FAIRNESS_EN
    chk("starve_mem_acks_before_if", mem_at_if_ack - m0, SMAX);
`else
    chk("starve_mem_acks_before_if", mem_at_if_ack - m0, 6);
`endif

    // Random concurrent traffic.
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) step();
        if_txn(32'($urandom_range(0, 15)));
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) step();
        mem_txn(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)),
                $urandom, 4'($urandom_range(0, 15)));
      end
    join

    repeat (10) step();
    chk("if_queue_drained", if_tq.size() + if_dq.size(), 0);
    chk("mem_queue_drained", mem_tq.size() + mem_dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency instruction/data memory between the CPU fetch stage (IF) and the load/store stage (MEM) in the minimal SOPC. It grants one access at a time, drives the memory strobes, and captures read data into a per-requester return register. It raises a stall request to the pipeline control while any requester is waiting.

## Interface
- `LATENCY`, 2: cycles from the memory strobe cycle to valid `ram_rdata_i`; must be ≥1.
- `STARVE_MAX`, 4: consecutive MEM grants tolerated while IF waits. Used only with the fairness feature.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req_i` in 1: IF read request; held until ack.
- `if_addr_i` in 32: IF word address.
- `if_data_o` out 32: fetched instruction; valid in the ack cycle and held afterwards.
- `if_ack_o` out 1: one-cycle completion pulse.
- `mem_req_i` in 1: MEM request; held until ack.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in 32: MEM address.
- `mem_wdata_i` in 32: write data.
- `mem_sel_i` in 4: byte enables.
- `mem_data_o` out 32: load data; valid in the ack cycle; unchanged by writes.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `stallreq_o` out 1: combinational, `(if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)`.
- `ram_ce_o` out 1: memory strobe, high for exactly one cycle per access.
- `ram_we_o` out 1: write strobe; only high together with `ram_ce_o`.
- `ram_addr_o` out 32: registered access address.
- `ram_wdata_o` out 32: registered write data.
- `ram_sel_o` out 4: registered byte enables; `4'b1111` for IF reads.
- `ram_rdata_i` in 32: read data, valid `LATENCY` cycles after the strobe cycle.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Requests are sampled only in this state.
  - If any request is pending, latch the winner's id, address, data, sel and we into registers and go to ISSUE.
  - Priority: MEM beats IF when both are asserted.
- **ISSUE:** drive `ram_ce_o` = 1 and `ram_we_o` = latched we. Clear the wait counter and go to WAIT.
- **WAIT:**
  - Counter increments each cycle, 1..LATENCY.
  - On the cycle where count == LATENCY, register `ram_rdata_i` into the winner's data register; writes do not capture.
  - Then go to DONE.
- **DONE:**
  - Pulse the winner's ack for one cycle.
  - Requests are ignored in this state; go to IDLE next cycle.
  - Requesters must drop or replace `req` in the cycle after ack.
- `ram_addr_o`, `ram_wdata_o` and `ram_sel_o` hold their last values outside ISSUE.
- Reset values:
  - All outputs 0.
  - `if_data_o` and `mem_data_o` = 32'h0.
  - State IDLE, counters 0.
- Reset mid-access:
  - Next state is IDLE.
  - No ack is issued for the aborted access, and `ram_ce_o` is low from the next cycle.
  - Late `ram_rdata_i` is ignored.
- A request deasserted before ack is illegal. Its behaviour is unspecified, but the FSM must still return to IDLE.

## Timing
- A request first seen in IDLE at cycle 0 produces:
  - `ram_ce_o` at cycle 1;
  - data capture at cycle 1+LATENCY;
  - ack at cycle 2+LATENCY.
- Back-to-back throughput: one access per LATENCY+3 cycles.
- Simultaneous requests: MEM is served first. IF is served in the IDLE cycle following MEM's DONE.
- `stallreq_o` is low in the ack cycle when only the acked requester was pending.

## Configuration
- Macro `MEM_ARB_FAIRNESS_EN`.
- **Defined:**
  - A 3-bit-min starve counter increments on each MEM grant made while `if_req_i` = 1.
  - When the counter equals `STARVE_MAX`, the next IDLE arbitration with `if_req_i` = 1 grants IF even if `mem_req_i` = 1.
  - The counter clears on any IF grant, when `if_req_i` = 0 in IDLE, and on reset.
- **Undefined:** strict MEM priority; no starve counter is present.

## Test plan
- **Reset:** assert `rst` for 2 cycles. All outputs are 0 and `stallreq_o` = 0 with no requests.
- **Single IF read:**
  - Setup: LATENCY = 2; `if_req_i` = 1 with `if_addr_i` = 32'h10 at cycle 0; memory returns 32'h3401_0020.
  - Expect: `ram_ce_o` at cycle 1, `if_ack_o` at cycle 4, `if_data_o` = 32'h3401_0020, `stallreq_o` high in cycles 0–3.
- **MEM write:**
  - Setup: addr 32'h100, wdata 32'hDEAD_BEEF, sel 4'b0011.
  - Expect: one cycle with `ram_ce_o` = `ram_we_o` = 1 carrying those values; `mem_ack_o` 3 cycles later; `mem_data_o` unchanged.
- **Collision:**
  - Setup: IF and MEM read requests asserted in the same cycle.
  - Expect: MEM acked at cycle 4, IF strobe at cycle 6, IF acked at cycle 9.
- **Reset mid-WAIT:**
  - Setup: assert `rst` during WAIT of an IF read.
  - Expect: no `if_ack_o`, IDLE next cycle; a new request completes normally afterwards.
- **Fairness:**
  - Setup: with `MEM_ARB_FAIRNESS_EN` and `STARVE_MAX` = 4, hold MEM continuously requesting with IF pending.
  - Expect: exactly 4 MEM acks, then an IF ack. Without the macro, IF is never acked while MEM keeps requesting.
